fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus bundle: instruction memory request/response and decode handoff.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
    input  imem_valid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
    output imem_valid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetcher with 2-entry buffer and redirect handling.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect target traps to HALT instead of being aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic        req_c, push, pop, wr_idx;
  logic        bad_target;
  logic [31:0] target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_err_q, misalign_err_d;
  assign bad_target = (bus.redirect_pc[1:0] != 2'b00);
  assign target_pc  = bus.redirect_pc;
  assign misalign_err_d = misalign_err_q | (bus.redirect & bad_target & (state_q != HALT));
  assign bus.misalign_err = misalign_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_err_q <= 1'b0;
    else     misalign_err_q <= misalign_err_d;
  end
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
  assign bad_target = 1'b0;
  assign target_pc  = {bus.redirect_pc[31:2], 2'b00};
  assign bus.misalign_err = 1'b0;
`endif

  assign wr_idx = head_q ^ count_q[0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    head_d       = head_q;
    count_d      = count_q;
    req_c        = 1'b0;
    push         = 1'b0;
    pop          = (count_q != 2'd0) && bus.instr_ready && !bus.redirect && (state_q != HALT);

    case (state_q)
      IDLE: begin
        if (!bus.redirect && count_q != 2'd2) begin
          req_c      = 1'b1;
          req_addr_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          state_d = bus.imem_valid ? IDLE : DROP;
        end else if (bus.imem_valid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        // A redirect here only moves pc; the pending response still has to drain.
        if (bus.imem_valid) state_d = IDLE;
      end
      default: ;
    endcase

    if (bus.redirect && state_q != HALT) begin
      pc_d    = target_pc;
      count_d = 2'd0;
      if (bad_target) state_d = HALT;
    end else begin
      if (pop) head_d = ~head_q;
      if (push) begin
        fifo_instr_d[wr_idx] = bus.imem_rdata;
        fifo_pc_d[wr_idx]    = req_addr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= 32'h0;
        fifo_pc_q[i]    <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      head_q       <= head_d;
      count_q      <= count_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

  assign bus.imem_req    = req_c & ~rst;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (count_q != 2'd0);
  assign bus.instr       = (count_q != 2'd0) ? fifo_instr_q[head_q] : 32'h0;
  assign bus.instr_pc    = (count_q != 2'd0) ? fifo_pc_q[head_q]    : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven directed test of fetch_unit.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        mv;
    logic [31:0] md;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic [31:0] rpc, input logic mv, input logic [31:0] md,
                     input logic rdy, input logic e_req, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_ipc, input logic [31:0] e_instr);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.mv = mv; v.md = md; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_instr = e_instr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rd, input logic [31:0] rpc, input logic mv,
                       input logic [31:0] md, input logic rdy);
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_valid  = mv;
    bus.imem_rdata  = md;
    bus.instr_ready = rdy;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // streaming with 1-cycle memory
    add(0, 0, 0, 0,            1, 1, 32'h0,  0, 0, 0);
    add(0, 0, 1, 32'hA000_0000,1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            1, 1, 32'h4,  1, 32'h0, 32'hA000_0000);
    add(0, 0, 1, 32'hA000_0004,1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            1, 1, 32'h8,  1, 32'h4, 32'hA000_0004);
    add(0, 0, 1, 32'hA000_0008,1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            1, 1, 32'hC,  1, 32'h8, 32'hA000_0008);
    // decode stalls for 10 cycles: buffer fills to 2, requests stop
    add(0, 0, 1, 32'hA000_000C,0, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            0, 1, 32'h10, 1, 32'hC, 32'hA000_000C);
    add(0, 0, 1, 32'hA000_0010,0, 0, 0,      1, 32'hC, 32'hA000_000C);
    for (int i = 0; i < 7; i++)
      add(0, 0, 0, 0,          0, 0, 0,      1, 32'hC, 32'hA000_000C);
    add(0, 0, 0, 0,            1, 0, 0,      1, 32'hC, 32'hA000_000C);
    add(0, 0, 0, 0,            1, 1, 32'h14, 1, 32'h10, 32'hA000_0010);
    // redirect while waiting, response 3 cycles later is dropped
    add(1, 32'h100, 0, 0,      1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            1, 0, 0,      0, 0, 0);
    add(0, 0, 1, 32'hDEAD_BEEF,1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            1, 1, 32'h100,0, 0, 0);
    add(0, 0, 1, 32'hB000_0100,1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            0, 1, 32'h104,1, 32'h100, 32'hB000_0100);
    // redirect coincident with response and pop
    add(1, 32'h200, 1, 32'hB000_0104, 1, 0, 0, 1, 32'h100, 32'hB000_0100);
    add(0, 0, 0, 0,            1, 1, 32'h200,0, 0, 0);
    add(0, 0, 1, 32'hC000_0200,1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            1, 1, 32'h204,1, 32'h200, 32'hC000_0200);
    // pc wraparound
    add(1, 32'hFFFF_FFFC, 1, 32'hC000_0204, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,            1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    add(0, 0, 1, 32'hD000_FFFC,1, 0, 0,      0, 0, 0);
    add(0, 0, 0, 0,            1, 1, 32'h0,  1, 32'hFFFF_FFFC, 32'hD000_FFFC);

    #1;
    chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_iv", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_err", {31'h0, bus.misalign_err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].rpc, vecs[i].mv, vecs[i].md, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, bus.imem_req}, {31'h0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_iv", i), {31'h0, bus.instr_valid}, {31'h0, vecs[i].e_iv});
      chk($sformatf("v%0d_ipc", i), bus.instr_pc, vecs[i].e_ipc);
      chk($sformatf("v%0d_instr", i), bus.instr, vecs[i].e_instr);
      @(negedge clk);
    end

    // reset in WAIT, late response after release ignored
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rstw_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rstw_iv", {31'h0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 32'h5555_5555, 1'b0);
    #1;
    chk("late_req", {31'h0, bus.imem_req}, 32'h1);
    chk("late_addr", bus.imem_addr, 32'h0);
    chk("late_iv", {31'h0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("late_drop_iv", {31'h0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'hE000_0000, 1'b0);
    #1;
    chk("resp_req", {31'h0, bus.imem_req}, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("post_iv", {31'h0, bus.instr_valid}, 32'h1);
    chk("post_instr", bus.instr, 32'hE000_0000);
    chk("post_ipc", bus.instr_pc, 32'h0);
    chk("post_addr", bus.imem_addr, 32'h4);
    @(negedge clk);

    // misaligned redirect while waiting
    drive(1'b1, 32'h102, 1'b0, 32'h0, 1'b0);
    #1;
    chk("mis_iv_before", {31'h0, bus.instr_valid}, 32'h1);
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, i[0], 32'h1234_5678, 1'b1);
      #1;
      chk($sformatf("halt%0d_err", i), {31'h0, bus.misalign_err}, 32'h1);
      chk($sformatf("halt%0d_req", i), {31'h0, bus.imem_req}, 32'h0);
      chk($sformatf("halt%0d_iv", i), {31'h0, bus.instr_valid}, 32'h0);
      @(negedge clk);
    end
`else
    drive(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
    #1;
    chk("drop_err", {31'h0, bus.misalign_err}, 32'h0);
    chk("drop_iv", {31'h0, bus.instr_valid}, 32'h0);
    chk("drop_req", {31'h0, bus.imem_req}, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("align_req", {31'h0, bus.imem_req}, 32'h1);
    chk("align_addr", bus.imem_addr, 32'h100);
    chk("align_err", {31'h0, bus.misalign_err}, 32'h0);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
